apb_slave_regfile: RTL
======================

# apb_slave_regfile

APB completer that terminates transfers issued by the APB bridge/master on one slave select, backed by a DEPTH×DW register file. Inserts a programmable number of wait states, flags out-of-range addresses with PSLVERR, and suppresses writes to them. Two instances sit behind the bridge to form the two-slave subsystem; the bench drives the master side through the existing APB driver.

## Interface
Parameters:
- AW, 8, address width (paddr)
- DW, 8, data width (pwdata/prdata)
- DEPTH, 64, number of implemented registers; legal addresses 0..DEPTH-1 (DEPTH ≤ 2**AW)
- WAIT_CYCLES, 1, wait states inserted per transfer (0..15)

Ports (one clock; reset is asynchronous and active-low):
- pclk  in  1  clock, all state on rising edge
- presetn  in  1  asynchronous active-low reset
- psel  in  1  slave select
- penable  in  1  access-phase indicator
- pwrite  in  1  1 = write, 0 = read
- paddr  in  AW  byte/word address (one register per address)
- pwdata  in  DW  write data
- prdata  out  DW  read data, valid when pready=1 on a read
- pready  out  1  transfer completion
- pslverr  out  1  error response, valid only with pready=1

## Operation
- States: IDLE, WAIT, READY. All outputs driven from registers; no combinational input→output path.
- IDLE: at edge with psel=1, penable=0 (setup phase): latch paddr, pwrite, pwdata; err = (paddr ≥ DEPTH); cnt ← WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else READY.
- WAIT: each edge cnt decrements; when cnt=1 at the edge, go to READY. pready=0.
- On READY entry: pready←1; pslverr←err; prdata←mem[addr] if read and !err, else 0.
- READY: at edge with psel=1, penable=1: if write and !err, mem[addr]←latched pwdata; clear pready, pslverr, prdata to 0; go to IDLE.
- Abort: psel=0 sampled in WAIT or READY → IDLE, outputs cleared, no write.
- psel=1, penable=1 sampled in IDLE (missing setup) → ignored, stay IDLE.
- Error transfers complete normally (same wait states) with pslverr=1; memory unchanged; prdata=0.
- Write data used is the value latched at setup; later pwdata changes ignored.

## Timing
- Reset (async, presetn=0): state IDLE, cnt=0, pready=0, pslverr=0, prdata=0, all mem entries 0. Takes effect immediately, mid-transfer included; transfer in flight is dropped, no write.
- Transfer length from setup cycle to completion edge inclusive: WAIT_CYCLES+2 cycles. WAIT_CYCLES=0: setup T0, access T1 with pready=1, completes at end of T1.
- pready is high for exactly one cycle per completed transfer.
- Back-to-back: new setup may be sampled on the first edge after completion (state already IDLE); no dead cycle required.
- Write visible to a read whose setup is sampled at or after the completion edge of the write.
- paddr width compare is unsigned; DEPTH=2**AW makes err constantly 0.

## Test plan
- Reset: presetn=0 mid-WAIT → pready=0, pslverr=0, prdata=0 immediately; subsequent read of addr 0x05 returns 0x00.
- Write/read, WAIT_CYCLES=1: write 0xA5 to 0x10 (pready high in 3rd cycle), then read 0x10 → prdata=0xA5, pslverr=0, total 3 cycles each.
- WAIT_CYCLES=0 back-to-back: write 0x3C to 0x3F then immediate read 0x3F → each 2 cycles, prdata=0x3C, no idle cycle between.
- Out-of-range: write 0xFF to 0x40, read 0x40 → pslverr=1 with pready both times, prdata=0; read 0x00 still 0x00 (no aliasing).
- Abort: setup write 0x77 to 0x01, drop psel during WAIT → no pready pulse; read 0x01 returns prior value 0x00.
- Protocol: penable=1 with psel=1 in IDLE without setup → no pready, state stays IDLE; next proper transfer completes normally.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer backed by a DEPTH x DW register file, with programmable wait states
// and PSLVERR on out-of-range addresses. All outputs come straight from flops.
module apb_slave_regfile #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr,
  output logic [1:0]    dbg_state_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a transfer is a setup edge (psel=1, penable=0) followed by access
  // edges; it completes on the edge where pready=1 and psel=1, penable=1 are sampled.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            err_q, err_d;
  logic            pready_q, pready_d;
  logic            pslverr_q, pslverr_d;
  logic [DW-1:0]   prdata_q, prdata_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic            mem_we;
  logic [31:0]     paddr_ext;
  logic            setup_err;

  assign paddr_ext = 32'(paddr);
  assign setup_err = (paddr_ext >= 32'(DEPTH));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    mem_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          err_d   = setup_err;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d   = ST_READY;
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = (!pwrite && !setup_err) ? mem_q[paddr[IW-1:0]] : '0;
          end
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d   = ST_READY;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (!write_q && !err_q) ? mem_q[addr_q[IW-1:0]] : '0;
          end
        end
      end
      ST_READY: begin
        // Either completion (psel & penable) or abort (psel dropped); only completion writes.
        if (!psel || penable) begin
          mem_we    = psel && write_q && !err_q;
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q[IW-1:0]] <= wdata_q;
    end
  end

  assign prdata      = prdata_q;
  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign dbg_state_o = state_q;

endmodule
